sudoku_puzzle_loader: RTL and testbench

SUDOKU_PUZZLE_LOADER -- requirements
Module: sudoku_puzzle_loader

---
 rtl/sudoku_puzzle_loader.sv | 172 +++++++++++++++++
 tb/tb_sudoku_puzzle_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_puzzle_loader.sv
// Streams an 81-cell puzzle from a synchronous ROM into a cell-serial solver,
// pacing Enter/Next handshakes with GAP idle cycles and finishing with Start.
module sudoku_puzzle_loader #(
    parameter int GAP = 4
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       Go,
    input  logic       Abort,
    output logic [6:0] RomAddr,
    input  logic [3:0] RomData,
    output logic [3:0] InputValue,
    output logic       Enter,
    output logic       Next,
    output logic       Start,
    output logic [3:0] Row,
    output logic [3:0] Col,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_CAPTURE = 4'd2,
        S_ENTER   = 4'd3,
        S_HOLD_E  = 4'd4,
        S_NEXT    = 4'd5,
        S_HOLD_N  = 4'd6,
        S_START   = 4'd7,
        S_DONE    = 4'd8,
        S_ERR     = 4'd9
    } state_t;

    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
    localparam logic [6:0] LAST_CELL = 7'd80;

    // A ROM nibble is a legal cell value when blank (0) or a given digit 1..9.
    function automatic logic is_legal_cell(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    state_t     state_r, state_s;
    logic [6:0] cell_r, cell_s;
    logic [3:0] row_r, row_s;
    logic [3:0] col_r, col_s;
    logic [3:0] value_r, value_s;
    logic [7:0] gap_r, gap_s;
    logic       enter_r, enter_s;
    logic       next_r, next_s;
    logic       start_r, start_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       err_r, err_s;

    // State and every output register; outputs are precomputed from the next state.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_r <= S_IDLE;
            cell_r  <= 7'd0;
            row_r   <= 4'd0;
            col_r   <= 4'd0;
            value_r <= 4'd0;
            gap_r   <= 8'd0;
            enter_r <= 1'b0;
            next_r  <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cell_r  <= cell_s;
            row_r   <= row_s;
            col_r   <= col_s;
            value_r <= value_s;
            gap_r   <= gap_s;
            enter_r <= enter_s;
            next_r  <= next_s;
            start_r <= start_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    // Next-state logic; Abort overrides every transition and clears the datapath.
    always_comb begin
        state_s = state_r;
        cell_s  = cell_r;
        row_s   = row_r;
        col_s   = col_r;
        value_s = value_r;
        gap_s   = 8'd0;
        if (Abort) begin
            state_s = S_IDLE;
            cell_s  = 7'd0;
            row_s   = 4'd0;
            col_s   = 4'd0;
            value_s = 4'd0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Go) begin
                        state_s = S_FETCH;
                        cell_s  = 7'd0;
                        row_s   = 4'd0;
                        col_s   = 4'd0;
                    end else begin
                        state_s = state_r;
                    end
                end
                S_FETCH: state_s = S_CAPTURE;
                S_CAPTURE: begin
                    if (is_legal_cell(RomData)) begin
                        value_s = RomData;
                        state_s = S_ENTER;
                    end else begin
                        state_s = S_ERR;
                    end
                end
                S_ENTER: state_s = S_HOLD_E;
                S_HOLD_E: begin
                    if (gap_r != GAP_LAST) begin
                        gap_s = gap_r + 8'd1;
                    end else if (cell_r == LAST_CELL) begin
                        state_s = S_START;
                    end else begin
                        state_s = S_NEXT;
                    end
                end
                S_NEXT: state_s = S_HOLD_N;
                S_HOLD_N: begin
                    if (gap_r != GAP_LAST) begin
                        gap_s = gap_r + 8'd1;
                    end else begin
                        state_s = S_FETCH;
                        cell_s  = cell_r + 7'd1;
                        // Row-major walk: column wraps after 8 and bumps the row.
                        if (col_r == 4'd8) begin
                            col_s = 4'd0;
                            row_s = row_r + 4'd1;
                        end else begin
                            col_s = col_r + 4'd1;
                        end
                    end
                end
                S_START: state_s = S_DONE;
                default: state_s = S_IDLE;
            endcase
        end
        enter_s = (state_s == S_ENTER);
        next_s  = (state_s == S_NEXT);
        start_s = (state_s == S_START);
        done_s  = (state_s == S_DONE);
        err_s   = (state_s == S_ERR);
        busy_s  = !((state_s == S_IDLE) || (state_s == S_DONE) || (state_s == S_ERR));
    end

    assign RomAddr    = cell_r;
    assign InputValue = value_r;
    assign Row        = row_r;
    assign Col        = col_r;
    assign Enter      = enter_r;
    assign Next       = next_r;
    assign Start      = start_r;
    assign Busy       = busy_r;
    assign Done       = done_r;
    assign Err        = err_r;

endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Directed bench: table of whole-load scenarios on GAP=4 and GAP=1 instances,
// plus hand-written Abort and mid-load Reset sequences.
module tb_sudoku_puzzle_loader;

    logic board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    int cyc = 0;
    always @(posedge board_clk) cyc <= cyc + 1;

    logic sel;
    logic reset_a, go_a, abort_a;
    logic [3:0] rom [0:80];

    logic [6:0] addr4, addr1;
    logic [3:0] rd4, rd1, val4, val1, row4, row1, col4, col1;
    logic en4, en1, nx4, nx1, st4, st1, busy4, busy1, done4, done1, err4, err1;

    sudoku_puzzle_loader #(.GAP(4)) dut4 (
        .board_clk(board_clk), .Reset(sel ? 1'b1 : reset_a), .Go(sel ? 1'b0 : go_a),
        .Abort(sel ? 1'b0 : abort_a), .RomAddr(addr4), .RomData(rd4), .InputValue(val4),
        .Enter(en4), .Next(nx4), .Start(st4), .Row(row4), .Col(col4),
        .Busy(busy4), .Done(done4), .Err(err4));

    sudoku_puzzle_loader #(.GAP(1)) dut1 (
        .board_clk(board_clk), .Reset(sel ? reset_a : 1'b1), .Go(sel ? go_a : 1'b0),
        .Abort(sel ? abort_a : 1'b0), .RomAddr(addr1), .RomData(rd1), .InputValue(val1),
        .Enter(en1), .Next(nx1), .Start(st1), .Row(row1), .Col(col1),
        .Busy(busy1), .Done(done1), .Err(err1));

    // synchronous puzzle ROMs: data valid the cycle after the address
    always @(posedge board_clk) begin
        rd4 <= (addr4 <= 7'd80) ? rom[int'(addr4)] : 4'd0;
        rd1 <= (addr1 <= 7'd80) ? rom[int'(addr1)] : 4'd0;
    end

    wire [6:0] addr = sel ? addr1 : addr4;
    wire [3:0] val  = sel ? val1  : val4;
    wire [3:0] row  = sel ? row1  : row4;
    wire [3:0] col  = sel ? col1  : col4;
    wire en = sel ? en1 : en4, nx = sel ? nx1 : nx4, st = sel ? st1 : st4;
    wire busy = sel ? busy1 : busy4, done = sel ? done1 : done4, err = sel ? err1 : err4;
    wire [24:0] all_out = {addr, val, en, nx, st, row, col, busy, done, err};

    int total = 0, bad = 0;
    int t0 = 0, period = 12;
    int en_cnt, nx_cnt, st_cnt, st_cyc, first_en, first_nx, last_en, viol, valbad;
    logic prev_p = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge board_clk);
        #1;
    endtask

    task automatic clear_counts();
        en_cnt = 0; nx_cnt = 0; st_cnt = 0; st_cyc = -1;
        first_en = -1; first_nx = -1; last_en = -1; viol = 0; valbad = 0;
    endtask

    // pulse monitor: counts, timing, value/coordinate check, exclusivity
    always @(negedge board_clk) begin : mon
        int rel;
        rel = cyc - t0;
        if (en) begin
            if (first_en < 0) first_en = rel;
            else if (rel - last_en != period) viol++;
            last_en = rel;
            if (en_cnt > 80) valbad++;
            else if (val != rom[en_cnt] || int'(row) != en_cnt / 9 || int'(col) != en_cnt % 9) valbad++;
            en_cnt++;
        end
        if (nx) begin
            if (first_nx < 0) first_nx = rel;
            nx_cnt++;
        end
        if (st) begin
            st_cnt++;
            st_cyc = rel;
        end
        if ((int'(en) + int'(nx) + int'(st)) > 1) viol++;
        if ((en || nx || st) && prev_p) viol++;
        prev_p = en || nx || st;
    end

    typedef struct {
        bit gap1; bit pat; int bad_idx; int bad_val; bit rep;
        int en; int nx; int st; int stc; int fe; int fn; int dn; int er; int row; int col; int val;
    } scn_t;
    scn_t tbl [6];

    task automatic fill_rom(input bit pat);
        for (int i = 0; i < 81; i++) rom[i] = pat ? 4'((i % 9) + 1) : 4'd5;
    endtask

    task automatic start_load();
        clear_counts();
        go_a = 1'b1;
        t0 = cyc;
        step();
        go_a = 1'b0;
    endtask

    task automatic wait_end(input string nm, input bit rep);
        int k;
        k = 0;
        while (!(done || err) && k < 3000) begin
            step();
            go_a = rep && ((cyc - t0) == 5 || (cyc - t0) == 500);
            k++;
        end
        go_a = 1'b0;
        chk({nm, ".finished"}, int'(done || err), 1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, -1, 0, 1'b0, 81, 80, 1, 968, 3, 8, 1, 0, 8, 8, 5};
        tbl[1] = '{1'b0, 1'b1, 10, 10, 1'b0, 10, 10, 0, -1, 3, 8, 0, 1, 1, 1, 1};
        tbl[2] = '{1'b0, 1'b0, -1, 0, 1'b1, 81, 80, 1, 968, 3, 8, 1, 0, 8, 8, 5};
        tbl[3] = '{1'b0, 1'b1, 80, 15, 1'b0, 80, 80, 0, -1, 3, 8, 0, 1, 8, 8, 8};
        tbl[4] = '{1'b0, 1'b1, 0, 12, 1'b0, 0, 0, 0, -1, -1, -1, 0, 1, 0, 0, -1};
        tbl[5] = '{1'b1, 1'b1, -1, 0, 1'b0, 81, 80, 1, 485, 3, 5, 1, 0, 8, 8, 9};

        sel = 1'b0; reset_a = 1'b1; go_a = 1'b0; abort_a = 1'b0;
        fill_rom(1'b0);
        clear_counts();
        step();
        chk("reset.outputs", int'(all_out), 0);
        reset_a = 1'b0;
        step(); step();
        chk("post_reset.idle", int'(all_out), 0);

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("scn%0d", i);
            sel = tbl[i].gap1;
            period = tbl[i].gap1 ? 6 : 12;
            fill_rom(tbl[i].pat);
            if (tbl[i].bad_idx >= 0) rom[tbl[i].bad_idx] = 4'(tbl[i].bad_val);
            step(); step();
            start_load();
            wait_end(nm, tbl[i].rep);
            for (int k = 0; k < 6; k++) step();
            chk({nm, ".enters"}, en_cnt, tbl[i].en);
            chk({nm, ".nexts"}, nx_cnt, tbl[i].nx);
            chk({nm, ".starts"}, st_cnt, tbl[i].st);
            chk({nm, ".start_cycle"}, st_cyc, tbl[i].stc);
            chk({nm, ".first_enter"}, first_en, tbl[i].fe);
            chk({nm, ".first_next"}, first_nx, tbl[i].fn);
            chk({nm, ".done"}, int'(done), tbl[i].dn);
            chk({nm, ".err"}, int'(err), tbl[i].er);
            chk({nm, ".busy"}, int'(busy), 0);
            chk({nm, ".row"}, int'(row), tbl[i].row);
            chk({nm, ".col"}, int'(col), tbl[i].col);
            if (tbl[i].val >= 0) chk({nm, ".value"}, int'(val), tbl[i].val);
            chk({nm, ".enter_values"}, valbad, 0);
            chk({nm, ".pulse_rules"}, viol, 0);
        end

        // Abort in HOLD_N of cell 40
        sel = 1'b0; period = 12;
        fill_rom(1'b1);
        step();
        start_load();
        for (int k = 0; k < 2000 && nx_cnt < 41; k++) step();
        chk("abort.reached_cell40", nx_cnt, 41);
        step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort.cleared", int'(all_out), 0);
        for (int k = 0; k < 30; k++) step();
        chk("abort.enters_frozen", en_cnt, 41);
        chk("abort.nexts_frozen", nx_cnt, 41);
        chk("abort.no_start", st_cnt, 0);
        start_load();
        wait_end("abort_reload", 1'b0);
        step();
        chk("abort_reload.enters", en_cnt, 81);
        chk("abort_reload.nexts", nx_cnt, 80);
        chk("abort_reload.start_cycle", st_cyc, 968);
        chk("abort_reload.done", int'(done), 1);

        // Reset at cycle 300 for 3 cycles
        step();
        start_load();
        while ((cyc - t0) < 300) step();
        #2 reset_a = 1'b1;
        #1 chk("reset_mid.async_zero", int'(all_out), 0);
        step(); step(); step();
        reset_a = 1'b0;
        clear_counts();
        for (int k = 0; k < 20; k++) step();
        chk("reset_mid.no_enter", en_cnt, 0);
        chk("reset_mid.no_next", nx_cnt, 0);
        chk("reset_mid.idle", int'(all_out), 0);
        start_load();
        wait_end("reset_reload", 1'b0);
        step();
        chk("reset_reload.enters", en_cnt, 81);
        chk("reset_reload.start_cycle", st_cyc, 968);
        chk("reset_reload.pulse_rules", viol + valbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
